imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port 2048x32 instruction BSRAM between the CPU fetch port and the
//  loader/debug port. Only the loader port writes program code. Drives ce/oce/wre/ad/din
//  and returns dout to whichever requester owns the read in flight. Prevents loader bursts
//  from starving fetch. Sits between the core, the UART loader and bsram_imem8k.
// PARAMETERS
//  AW         11  BSRAM word-address width (2048 words)
//  DW         32  data width
//  MAX_BURST  4   max consecutive loader grants while fetch waits (1..15)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  if_req     in   1   fetch request (read only)
//  if_addr    in   32  fetch byte address; word index = if_addr[AW+1:2]
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   if_rdata valid (1 cycle after if_gnt)
//  if_rdata   out  DW  fetched instruction
//  if_err     out  1   pulse with if_rvalid: misaligned or out-of-range fetch
//  ld_req     in   1   loader request
//  ld_we      in   1   1=write, 0=read
//  ld_addr    in   AW  loader word address
//  ld_wdata   in   DW  loader write data
//  ld_gnt     out  1   loader request accepted this cycle
//  ld_rvalid  out  1   ld_rdata valid (1 cycle after read grant)
//  ld_rdata   out  DW  loader read data
//  mem_ce     out  1   to BSRAM ce
//  mem_oce    out  1   to BSRAM oce (tied 1; bypass read mode)
//  mem_wre    out  1   to BSRAM wre
//  mem_reset  out  1   to BSRAM reset (tied 0)
//  mem_ad     out  AW  to BSRAM ad
//  mem_din    out  DW  to BSRAM din
//  mem_dout   in   DW  from BSRAM dout
// BEHAVIOUR
//  - Reset values: all gnt/rvalid/err/mem_ce/mem_wre = 0; rdata = 0; mem_ad/din = 0;
//    burst counter = 0; owner register = NONE.
//  - Grant is combinational in the request cycle: at most one of if_gnt/ld_gnt per cycle.
//    mem_ce = if_gnt|ld_gnt; mem_wre = ld_gnt&ld_we; mem_ad/mem_din muxed from the winner.
//  - Requester holds req/addr/data stable until gnt; a new request may follow in the next cycle
//    (back-to-back reads give one word per cycle).
//  - Priority: loader wins by default. burst_cnt increments on each ld_gnt while if_req=1;
//    when burst_cnt==MAX_BURST and if_req=1, fetch wins that cycle and burst_cnt clears.
//    burst_cnt also clears on any cycle with if_req=0.
//  - Read pipeline: owner register records the read grant (IF, LD or NONE); next cycle
//    the matching rvalid = 1 and rdata <= mem_dout. Writes produce no rvalid.
//  - if_err: fetch with if_addr[1:0]!=0 or if_addr[31:AW+2]!=0 is granted without
//    enabling memory (mem_ce=0); next cycle if_rvalid=1, if_err=1, if_rdata=32'h0000_0013 (NOP).
//  - Read of an address being written in the same cycle cannot occur (single port).
//    Loader write then fetch of the same word: fetch returns the new data.
//  - rdata holds its last value when rvalid=0.
//  - rst_n asserted mid-read: the in-flight rvalid is dropped and the owner register clears.
//    The BSRAM contents are unaffected.
// TESTING
//  1 Reset then idle: every output 0. mem_oce=1, mem_reset=0.
//  2 Fetch-only reads 0x0,0x4,0x8 back-to-back: if_gnt on 3 consecutive cycles,
//    if_rvalid on the next 3 cycles, data = words 0..2 of the init image.
//  3 Loader writes 0xDEADBEEF to word 5, then fetch of 0x14: if_rdata=0xDEADBEEF, if_err=0.
//  4 if_req and ld_req held high continuously, MAX_BURST=4: grant pattern LLLLF repeats,
//    and the fetch is never stalled for more than 4 cycles.
//  5 Fetch of 0x2 and of 0x2000: no mem_ce. if_rvalid=1, if_err=1, if_rdata=0x00000013.
//  6 rst_n pulsed low in the cycle after a loader read grant: ld_rvalid never asserts,
//    and after reset the first fetch completes normally.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction BSRAM between CPU fetch and the loader/debug port.
// Loader wins by default; a burst limit guarantees fetch a slot while it waits.
module imem_port_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic          mem_reset,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [DW-1:0] NOP_INSTR = DW'(32'h0000_0013);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_IF_ERR,
    OWN_LD
  } owner_t;

  owner_t        owner;
  logic [3:0]    burst_cnt;
  logic          if_bad;
  logic          fetch_turn;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] ld_hold;

  // A bad fetch is granted but never touches the memory; it answers with a NOP.
  assign if_bad     = (if_addr[1:0] != 2'b00) || (if_addr[31:AW+2] != '0);
  assign fetch_turn = (burst_cnt == 4'(MAX_BURST));

  assign if_gnt = if_req && (!ld_req || fetch_turn);
  assign ld_gnt = ld_req && !(if_req && fetch_turn);

  assign mem_oce   = 1'b1;
  assign mem_reset = 1'b0;
  assign mem_ce    = (if_gnt && !if_bad) || ld_gnt;
  assign mem_wre   = ld_gnt && ld_we;

  always_comb begin
    mem_ad  = '0;
    mem_din = '0;
    if (ld_gnt) begin
      mem_ad = ld_addr;
      if (ld_we) mem_din = ld_wdata;
    end else if (if_gnt && !if_bad) begin
      mem_ad = if_addr[AW+1:2];
    end
  end

  // Counts loader wins while fetch is waiting; fetch being served or idle resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      burst_cnt <= '0;
    end else if (ld_gnt) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      ld_rvalid <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      if_err    <= if_gnt && if_bad;
      ld_rvalid <= ld_gnt && !ld_we;
      if (if_gnt)
        owner <= if_bad ? OWN_IF_ERR : OWN_IF;
      else if (ld_gnt && !ld_we)
        owner <= OWN_LD;
      else
        owner <= OWN_NONE;
    end
  end

  // BSRAM in bypass mode presents dout in the cycle after the grant, so read data
  // is steered straight through and captured only to hold it between responses.
  always_comb begin
    if_rdata = if_hold;
    ld_rdata = ld_hold;
    case (owner)
      OWN_IF:     if_rdata = mem_dout;
      OWN_IF_ERR: if_rdata = NOP_INSTR;
      OWN_LD:     ld_rdata = mem_dout;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_hold <= '0;
      ld_hold <= '0;
    end else begin
      if (owner == OWN_IF || owner == OWN_IF_ERR) if_hold <= if_rdata;
      if (owner == OWN_LD) ld_hold <= ld_rdata;
    end
  end

endmodule
